// File: rtl/greater_bist_pkg.sv
// ============================================================================
// greater_bist_pkg : shared FSM state encodings and sizing helpers
// Revision 1.0
// ============================================================================
`default_nettype none

package greater_bist_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  // The settle counter only has to reach SETTLE-1; keep it at least one bit wide.
  function automatic int settle_width(input int settle);
    return (settle > 2) ? $clog2(settle) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/greater_bist_ref.sv
// ============================================================================
// greater_bist_ref : combinational golden model, unsigned a > b
// Revision 1.0
// ============================================================================
`default_nettype none

module greater_bist_ref #(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             gt_o
);

  assign gt_o = (a_i > b_i);

endmodule

`default_nettype wire

// File: rtl/greater_bist.sv
// ============================================================================
// greater_bist : exhaustive self-test engine for an unsigned a > b comparator
// Revision 1.0
// ============================================================================
`default_nettype none

module greater_bist #(
  parameter int WIDTH  = 2,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [WIDTH-1:0]     a,
  output logic [WIDTH-1:0]     b,
  input  logic                 dut_out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2*WIDTH:0]     err_count,
  output logic [2*WIDTH-1:0]   first_fail
);

  import greater_bist_pkg::*;

  localparam int VW = 2 * WIDTH;
  localparam int SW = settle_width(SETTLE);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
  localparam logic [VW-1:0] VEC_LAST    = {VW{1'b1}};

  state_e          state_q;
  logic [VW-1:0]   vec_q;
  logic [VW-1:0]   vec_d;
  logic [SW-1:0]   settle_q;
  logic [SW-1:0]   settle_d;
  logic [VW:0]     err_q;
  logic [VW:0]     err_d;
  logic [VW-1:0]   first_fail_q;
  logic            busy_q;
  logic            done_q;

  logic            expected;
  logic            mismatch;
  logic            vec_last;
  logic            settle_last;

  greater_bist_ref #(
    .WIDTH (WIDTH)
  ) u_ref (
    .a_i  (vec_q[VW-1:WIDTH]),
    .b_i  (vec_q[WIDTH-1:0]),
    .gt_o (expected)
  );

  always_comb begin
    vec_d       = vec_q + VW'(1);
    settle_d    = settle_q + SW'(1);
    err_d       = err_q + (VW+1)'(1);
    mismatch    = (dut_out != expected);
    vec_last    = (vec_q == VEC_LAST);
    settle_last = (settle_q == SETTLE_LAST);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      vec_q        <= '0;
      settle_q     <= '0;
      err_q        <= '0;
      first_fail_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q      <= DRIVE;
            vec_q        <= '0;
            settle_q     <= '0;
            err_q        <= '0;
            first_fail_q <= '0;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
          end
        end
        DRIVE: begin
          if (settle_last) begin
            state_q <= SAMPLE;
          end else begin
            settle_q <= settle_d;
          end
        end
        SAMPLE: begin
          // dut_out is judged exactly once per vector, on this exit edge.
          if (mismatch) begin
            err_q <= err_d;
            if (err_q == '0) begin
              first_fail_q <= vec_q;
            end
          end
          if (vec_last) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            vec_q    <= vec_d;
            settle_q <= '0;
            state_q  <= DRIVE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign a          = busy_q ? vec_q[VW-1:WIDTH] : '0;
  assign b          = busy_q ? vec_q[WIDTH-1:0]  : '0;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = done_q && (err_q == '0);
  assign err_count  = err_q;
  assign first_fail = first_fail_q;

endmodule

`default_nettype wire

// File: tb/tb_greater_bist.sv
// ============================================================================
// tb_greater_bist : directed-vector bench for greater_bist (SETTLE=1 and 3)
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_greater_bist;

  logic       clk = 1'b0;
  logic       rst;
  logic       start1, start3;
  logic       dut_out1, dut_out3;
  logic [1:0] a1, b1, a3, b3;
  logic       busy1, done1, pass1, busy3, done3, pass3;
  logic [4:0] err1, err3;
  logic [3:0] ff1, ff3;
  int         mode1 = 0;
  int         mode3 = 0;
  int         vecs  = 0;
  int         errs  = 0;

  always #5 clk = ~clk;

  // Comparator under test: 0 correct, 1 stuck-at-0, 2 a>=b, 3 a<=b.
  function automatic logic cmp(input int m, input logic [1:0] x, input logic [1:0] y);
    case (m)
      0:       return x > y;
      1:       return 1'b0;
      2:       return x >= y;
      default: return x <= y;
    endcase
  endfunction

  assign dut_out1 = cmp(mode1, a1, b1);
  assign dut_out3 = cmp(mode3, a3, b3);

  greater_bist #(.WIDTH(2), .SETTLE(1)) u_dut1 (
    .clk        (clk),
    .rst        (rst),
    .start      (start1),
    .a          (a1),
    .b          (b1),
    .dut_out    (dut_out1),
    .busy       (busy1),
    .done       (done1),
    .pass       (pass1),
    .err_count  (err1),
    .first_fail (ff1)
  );

  greater_bist #(.WIDTH(2), .SETTLE(3)) u_dut3 (
    .clk        (clk),
    .rst        (rst),
    .start      (start3),
    .a          (a3),
    .b          (b3),
    .dut_out    (dut_out3),
    .busy       (busy3),
    .done       (done3),
    .pass       (pass3),
    .err_count  (err3),
    .first_fail (ff3)
  );

  // Pulse start on the SETTLE=1 instance and count edges until done rises.
  task automatic run1(input int m, output int cyc);
    mode1 = m;
    @(negedge clk) start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    cyc = 0;
    while (done1 !== 1'b1 && cyc < 400) begin
      @(posedge clk);
      #1 cyc++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start1 = 1'b0; start3 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vecs++; if ({a1, b1, busy1, done1, pass1} !== 7'd0) begin errs++; $display("FAIL reset_ctl1: got %b expected 0", {a1, b1, busy1, done1, pass1}); end
    vecs++; if ({err1, ff1} !== 9'd0) begin errs++; $display("FAIL reset_res1: got %h expected 0", {err1, ff1}); end
    vecs++; if ({a3, b3, busy3, done3, pass3} !== 7'd0) begin errs++; $display("FAIL reset_ctl3: got %b expected 0", {a3, b3, busy3, done3, pass3}); end
    vecs++; if ({err3, ff3} !== 9'd0) begin errs++; $display("FAIL reset_res3: got %h expected 0", {err3, ff3}); end
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_correct;
    logic [3:0] ev;
    mode1 = 0;
    @(negedge clk) start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    for (int n = 0; n <= 32; n++) begin
      if (n < 32) begin
        ev = 4'(n / 2);
        vecs++; if ({a1, b1} !== ev) begin errs++; $display("FAIL correct_ab n=%0d: got %h expected %h", n, {a1, b1}, ev); end
        vecs++; if ({busy1, done1} !== 2'b10) begin errs++; $display("FAIL correct_busy n=%0d: got %b expected 10", n, {busy1, done1}); end
        @(posedge clk);
        #1;
      end else begin
        vecs++; if ({busy1, done1, pass1} !== 3'b011) begin errs++; $display("FAIL correct_done: got %b expected 011", {busy1, done1, pass1}); end
        vecs++; if (err1 !== 5'd0) begin errs++; $display("FAIL correct_err: got %0d expected 0", err1); end
        vecs++; if ({a1, b1} !== 4'd0) begin errs++; $display("FAIL correct_ab_done: got %h expected 0", {a1, b1}); end
      end
    end
  endtask

  task automatic test_stuck0;
    int cyc;
    run1(1, cyc);
    vecs++; if (cyc !== 32) begin errs++; $display("FAIL stuck0_latency: got %0d expected 32", cyc); end
    vecs++; if (err1 !== 5'd6) begin errs++; $display("FAIL stuck0_err: got %0d expected 6", err1); end
    vecs++; if (ff1 !== 4'b0100) begin errs++; $display("FAIL stuck0_first: got %b expected 0100", ff1); end
    vecs++; if ({done1, pass1} !== 2'b10) begin errs++; $display("FAIL stuck0_pass: got %b expected 10", {done1, pass1}); end
  endtask

  task automatic test_ge;
    int cyc;
    run1(2, cyc);
    vecs++; if (err1 !== 5'd4) begin errs++; $display("FAIL ge_err: got %0d expected 4", err1); end
    vecs++; if (ff1 !== 4'b0000) begin errs++; $display("FAIL ge_first: got %b expected 0000", ff1); end
    vecs++; if (pass1 !== 1'b0) begin errs++; $display("FAIL ge_pass: got %b expected 0", pass1); end
  endtask

  task automatic test_le;
    int cyc;
    run1(3, cyc);
    vecs++; if (err1 !== 5'd16) begin errs++; $display("FAIL le_err: got %0d expected 16", err1); end
    vecs++; if (ff1 !== 4'b0000) begin errs++; $display("FAIL le_first: got %b expected 0000", ff1); end
    vecs++; if (pass1 !== 1'b0) begin errs++; $display("FAIL le_pass: got %b expected 0", pass1); end
  endtask

  task automatic test_reset_midrun;
    int cyc;
    mode1 = 1;
    @(negedge clk) start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    vecs++; if ({a1, b1} !== 4'd5) begin errs++; $display("FAIL mid_ab: got %h expected 5", {a1, b1}); end
    vecs++; if ({err1, ff1} !== {5'd1, 4'd4}) begin errs++; $display("FAIL mid_res: got %0d/%h expected 1/4", err1, ff1); end
    #2 rst = 1'b1;
    #1;
    vecs++; if ({a1, b1, busy1, done1, pass1} !== 7'd0) begin errs++; $display("FAIL arst_ctl: got %b expected 0", {a1, b1, busy1, done1, pass1}); end
    vecs++; if ({err1, ff1} !== 9'd0) begin errs++; $display("FAIL arst_res: got %h expected 0", {err1, ff1}); end
    @(negedge clk) rst = 1'b0;
    run1(0, cyc);
    vecs++; if (cyc !== 32) begin errs++; $display("FAIL rerun_latency: got %0d expected 32", cyc); end
    vecs++; if ({done1, pass1, err1} !== {2'b11, 5'd0}) begin errs++; $display("FAIL rerun_pass: got %b expected 1100000", {done1, pass1, err1}); end
  endtask

  task automatic test_settle3;
    logic [3:0] ev;
    int cyc;
    mode3 = 0;
    @(negedge clk) start3 = 1'b1;
    @(posedge clk);
    #1 start3 = 1'b0;
    for (int n = 0; n <= 70; n++) begin
      if (n < 64) begin
        ev = 4'(n / 4);
        vecs++; if ({a3, b3} !== ev) begin errs++; $display("FAIL s3_ab n=%0d: got %h expected %h", n, {a3, b3}, ev); end
        vecs++; if ({busy3, done3} !== 2'b10) begin errs++; $display("FAIL s3_busy n=%0d: got %b expected 10", n, {busy3, done3}); end
      end else begin
        vecs++; if ({busy3, done3} !== 2'b01) begin errs++; $display("FAIL s3_done n=%0d: got %b expected 01", n, {busy3, done3}); end
      end
      start3 = (n == 5 || n == 40);
      if (n < 70) begin
        @(posedge clk);
        #1;
      end
    end
    vecs++; if ({pass3, err3} !== {1'b1, 5'd0}) begin errs++; $display("FAIL s3_pass: got %b expected 100000", {pass3, err3}); end
    start3 = 1'b1;
    @(posedge clk);
    #1;
    vecs++; if ({busy3, done3, a3, b3} !== 6'b100000) begin errs++; $display("FAIL s3_restart: got %b expected 100000", {busy3, done3, a3, b3}); end
    cyc = 0;
    repeat (3) begin
      @(posedge clk);
      #1 cyc++;
    end
    start3 = 1'b0;
    while (done3 !== 1'b1 && cyc < 400) begin
      @(posedge clk);
      #1 cyc++;
    end
    vecs++; if (cyc !== 64) begin errs++; $display("FAIL s3_relatency: got %0d expected 64", cyc); end
    vecs++; if (pass3 !== 1'b1) begin errs++; $display("FAIL s3_repass: got %b expected 1", pass3); end
  endtask

  initial begin
    rst = 1'b1; start1 = 1'b0; start3 = 1'b0;
    test_reset;
    test_correct;
    test_stuck0;
    test_ge;
    test_le;
    test_reset_midrun;
    test_settle3;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

`default_nettype wire
